// File: rtl/hamming_reg_ctrl_if.sv
// Host-side bundle for the Hamming shift-register sequencer.
// It carries the command, serial-in, serial-out and response channels.
// "master" is the host/bench side and "slave" is the controller side.
interface hamming_reg_ctrl_if #(
    parameter int WIDTH = 128,
    parameter int LEN_W = 8
) ();
    // command channel
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [LEN_W-1:0]  cmd_len;
    logic [WIDTH-1:0]  cmd_data;

    // serial bits into the register
    logic              si_valid;
    logic              si_ready;
    logic              si_data;

    // serial bits leaving the register
    logic              so_valid;
    logic              so_ready;
    logic              so_data;

    // response channel carrying the corrected register contents
    logic              rsp_valid;
    logic              rsp_ready;
    logic [WIDTH-1:0]  rsp_data;

    modport master (
        output cmd_valid, cmd_op, cmd_len, cmd_data,
        input  cmd_ready,
        output si_valid, si_data,
        input  si_ready,
        input  so_valid, so_data,
        output so_ready,
        input  rsp_valid, rsp_data,
        output rsp_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_len, cmd_data,
        output cmd_ready,
        input  si_valid, si_data,
        output si_ready,
        output so_valid, so_data,
        input  so_ready,
        output rsp_valid, rsp_data,
        input  rsp_ready
    );
endinterface

// File: rtl/hamming_reg_ctrl.sv
// Command sequencer for the Hamming-protected shift register.
// It takes one host command at a time: LOAD, SHR by N, SHL by N, or READ.
// Serial bits stream through the register during shifts.
// Each command ends with enable-low settle cycles so that the register writes back
// its single-bit correction. The corrected contents are then returned as a response.
module hamming_reg_ctrl #(
    parameter int WIDTH         = 128,
    parameter int LEN_W         = 8,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    hamming_reg_ctrl_if.slave    bus,
    output logic                 busy_o,
    output logic                 reg_enable_o,
    output logic [1:0]           reg_mode_o,
    output logic                 reg_load_o,
    output logic                 reg_serial_in_o,
    output logic [WIDTH-1:0]     reg_parallel_in_o,
    input  logic                 reg_serial_out_i,
    input  logic [WIDTH-1:0]     reg_parallel_out_i
);

    localparam logic [1:0] OP_LOAD   = 2'b00;
    localparam logic [1:0] OP_SHR    = 2'b01;
    localparam logic [1:0] OP_SHL    = 2'b10;
    localparam logic [1:0] OP_READ   = 2'b11;

    localparam logic [1:0] MODE_SHR  = 2'b00;
    localparam logic [1:0] MODE_SHL  = 2'b01;
    localparam logic [1:0] MODE_HOLD = 2'b11;

    localparam int               SET_W       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [LEN_W-1:0] LEN_MAX     = LEN_W'(WIDTH);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SHIFT  = 3'd2,
        ST_SETTLE = 3'd3,
        ST_RESP   = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [SET_W-1:0]   settle_q, settle_d;
    logic [WIDTH-1:0]   rsp_data_q, rsp_data_d;

    logic               cmd_ready_s;
    logic               si_ready_s;
    logic               so_valid_s;
    logic               so_data_s;
    logic               rsp_valid_s;
    logic               reg_enable_s;
    logic [1:0]         reg_mode_s;
    logic               reg_load_s;
    logic               reg_serial_in_s;
    logic [WIDTH-1:0]   reg_parallel_in_s;
    logic               xfer_s;

    // A bit moves in and out only when a source bit and a sink slot exist together.
    assign xfer_s = bus.si_valid & bus.so_ready;

    // State and datapath registers. Reset drops any command in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            op_q       <= 2'b00;
            cnt_q      <= '0;
            data_q     <= '0;
            settle_q   <= '0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            settle_q   <= settle_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    // Next-state logic and decode of the register pins and handshake outputs.
    always_comb begin
        state_d           = state_q;
        op_d              = op_q;
        cnt_d             = cnt_q;
        data_d            = data_q;
        settle_d          = settle_q;
        rsp_data_d        = rsp_data_q;
        cmd_ready_s       = 1'b0;
        si_ready_s        = 1'b0;
        so_valid_s        = 1'b0;
        so_data_s         = 1'b0;
        rsp_valid_s       = 1'b0;
        reg_enable_s      = 1'b0;
        reg_mode_s        = MODE_HOLD;
        reg_load_s        = 1'b0;
        reg_serial_in_s   = 1'b0;
        reg_parallel_in_s = '0;

        case (state_q)
            ST_IDLE: begin
                cmd_ready_s = 1'b1;
                if (bus.cmd_valid) begin
                    op_d     = bus.cmd_op;
                    data_d   = bus.cmd_data;
                    settle_d = '0;
                    // A shift longer than the register is the same as a full flush.
                    if (bus.cmd_len > LEN_MAX) begin
                        cnt_d = LEN_MAX;
                    end else begin
                        cnt_d = bus.cmd_len;
                    end
                    case (bus.cmd_op)
                        OP_LOAD: state_d = ST_LOAD;
                        OP_SHR,
                        OP_SHL: begin
                            if (bus.cmd_len == '0) begin
                                state_d = ST_SETTLE;
                            end else begin
                                state_d = ST_SHIFT;
                            end
                        end
                        OP_READ: state_d = ST_SETTLE;
                        default: state_d = ST_IDLE;
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_LOAD: begin
                reg_enable_s      = 1'b1;
                reg_load_s        = 1'b1;
                reg_parallel_in_s = data_q;
                state_d           = ST_SETTLE;
            end

            ST_SHIFT: begin
                if (op_q == OP_SHL) begin
                    reg_mode_s = MODE_SHL;
                end else begin
                    reg_mode_s = MODE_SHR;
                end
                // The outgoing bit is the one that leaves on this edge. The in and out
                // handshakes are tied together so that their counts always match.
                so_valid_s = bus.si_valid;
                so_data_s  = reg_serial_out_i;
                si_ready_s = bus.so_ready;
                if (xfer_s) begin
                    reg_enable_s    = 1'b1;
                    reg_serial_in_s = bus.si_data;
                    cnt_d           = cnt_q - LEN_W'(1);
                    if (cnt_q <= LEN_W'(1)) begin
                        state_d = ST_SETTLE;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end else begin
                    // Stall cycle: enable stays low, so the register can self-correct.
                    state_d = ST_SHIFT;
                end
            end

            ST_SETTLE: begin
                if (settle_q == SETTLE_LAST) begin
                    rsp_data_d = reg_parallel_out_i;
                    settle_d   = '0;
                    state_d    = ST_RESP;
                end else begin
                    settle_d   = settle_q + SET_W'(1);
                    state_d    = ST_SETTLE;
                end
            end

            ST_RESP: begin
                rsp_valid_s = 1'b1;
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.cmd_ready     = cmd_ready_s;
    assign bus.si_ready      = si_ready_s;
    assign bus.so_valid      = so_valid_s;
    assign bus.so_data       = so_data_s;
    assign bus.rsp_valid     = rsp_valid_s;
    assign bus.rsp_data      = rsp_data_q;

    assign busy_o            = (state_q != ST_IDLE);
    assign reg_enable_o      = reg_enable_s;
    assign reg_mode_o        = reg_mode_s;
    assign reg_load_o        = reg_load_s;
    assign reg_serial_in_o   = reg_serial_in_s;
    assign reg_parallel_in_o = reg_parallel_in_s;

endmodule
